iob_eth_rx_mii: RTL and testbench

- MII receive framer inside iob_eth; directly feeds the RX frame buffer that the CPU reads through ETH_DATA.
- Samples the 4-bit MII receive bus, strips preamble/SFD and assembles nibbles into bytes.
- Filters on destination MAC, writes bytes from dest MAC through FCS into the buffer, checks CRC-32, and reports status (ETH_STATUS bit1) until the CPU acknowledges through ETH_RCVACK.

---
 rtl/iob_eth_rx_mii_pkg.sv | 44 ++++
 rtl/iob_eth_rx_mii_if.sv | 17 +
 rtl/iob_eth_crc32.sv | 27 ++
 rtl/iob_eth_rx_mii.sv | 188 ++++++++++++++++++
 tb/tb_iob_eth_rx_mii.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_eth_rx_mii_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iob_eth_rx_mii_pkg
//  Purpose  : Shared Ethernet constants, receive-FSM state encoding and the
//             byte-serial CRC-32 step used by the iob_eth RX/TX paths.
//  Revision : 1.0 - initial release
// ============================================================================
package iob_eth_rx_mii_pkg;

    localparam logic [7:0]  C_ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  C_ETH_SFD      = 8'hD5;
    localparam int          C_MAC_ADDR_LEN = 6;
    localparam int          C_HDR_LEN      = 14;
    localparam int          C_MIN_FRAME    = 18;

    localparam logic [31:0] C_CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] C_CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] C_CRC_RESIDUE  = 32'hC704DD7B;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA_LO  = 3'd2,
        S_DATA_HI  = 3'd3,
        S_CHECK    = 3'd4,
        S_DONE     = 3'd5,
        S_DROP     = 3'd6
    } rx_state_t;

    // The register is kept MSB-first while each byte enters LSB first (the
    // wire order), so a good frame leaves the residue in its unreflected form.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ C_CRC_POLY;
            else                 c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_eth_rx_mii_if.sv
`default_nettype none
// ============================================================================
//  Module   : iob_eth_rx_mii_if
//  Purpose  : Byte write port from the receive framer into the RX buffer.
//  Revision : 1.0 - initial release
// ============================================================================
interface iob_eth_rx_mii_if #(
    parameter int ADDR_W = 11
);
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;

    modport master (output buf_we, output buf_addr, output buf_wdata);
    modport slave  (input  buf_we, input  buf_addr, input  buf_wdata);
endinterface
`default_nettype wire

// File: rtl/iob_eth_crc32.sv
`default_nettype none
// ============================================================================
//  Module   : iob_eth_crc32
//  Purpose  : Byte-wide Ethernet CRC-32 register with synchronous init and
//             enable; shared by the receive and transmit paths.
//  Revision : 1.0 - initial release
// ============================================================================
module iob_eth_crc32
    import iob_eth_rx_mii_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    // Init wins over enable so a new frame always starts from all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    crc <= C_CRC_INIT;
        else if (init) crc <= C_CRC_INIT;
        else if (en)   crc <= crc32_next(crc, data);
    end

endmodule
`default_nettype wire

// File: rtl/iob_eth_rx_mii.sv
`default_nettype none
// ============================================================================
//  Module   : iob_eth_rx_mii
//  Purpose  : MII receive framer: strips preamble/SFD, assembles bytes,
//             filters on destination MAC, writes the frame into the RX buffer
//             and holds CRC/length status until the CPU acknowledges.
//  Revision : 1.0 - initial release
// ============================================================================
module iob_eth_rx_mii
    import iob_eth_rx_mii_pkg::*;
#(
    parameter int BUF_ADDR_W = 11,
    parameter int BUF_OFFSET = 2,
    parameter bit MAC_FILTER = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_dv,
    input  logic [3:0]            rx_data,
    input  logic [47:0]           mac_addr,
    input  logic                  rcv_ack,
    iob_eth_rx_mii_if.master      buf_if,
    output logic                  rx_ready,
    output logic [BUF_ADDR_W-1:0] rx_nbytes,
    output logic                  crc_err,
    output logic                  len_err,
    output logic                  busy
);

    rx_state_t             r_state;
    rx_state_t             w_state_nxt;
    logic [3:0]            r_lo;
    logic [BUF_ADDR_W-1:0] r_cnt;
    logic                  r_ovf;
    logic                  r_own_ok;
    logic                  r_bc_ok;
    logic                  r_buf_we;
    logic [BUF_ADDR_W-1:0] r_buf_addr;
    logic [7:0]            r_buf_wdata;
    logic                  r_rx_ready;
    logic [BUF_ADDR_W-1:0] r_nbytes;
    logic                  r_crc_err;
    logic                  r_len_err;

    logic [7:0]            w_byte;
    logic [BUF_ADDR_W:0]   w_addr_sum;
    logic                  w_ovf_now;
    logic                  w_sfd_seen;
    logic                  w_byte_done;
    logic [7:0]            w_mac_byte;
    logic                  w_in_mac;
    logic                  w_own_next;
    logic                  w_bc_next;
    logic                  w_mac_reject;
    logic [31:0]           w_crc;

    assign w_byte      = {rx_data, r_lo};
    assign w_addr_sum  = (BUF_ADDR_W+1)'(BUF_OFFSET) + {1'b0, r_cnt};
    assign w_ovf_now   = w_addr_sum[BUF_ADDR_W];
    assign w_sfd_seen  = (r_state == S_PREAMBLE) && rx_dv && (rx_data == C_ETH_SFD[7:4]);
    assign w_byte_done = (r_state == S_DATA_HI) && rx_dv;

    // Own-MAC byte expected at the current destination position, first byte MSB.
    always_comb begin
        w_mac_byte = mac_addr[47:40];
        case (r_cnt[2:0])
            3'd1:    w_mac_byte = mac_addr[39:32];
            3'd2:    w_mac_byte = mac_addr[31:24];
            3'd3:    w_mac_byte = mac_addr[23:16];
            3'd4:    w_mac_byte = mac_addr[15:8];
            3'd5:    w_mac_byte = mac_addr[7:0];
            default: w_mac_byte = mac_addr[47:40];
        endcase
    end

    // Running unicast/broadcast match; the verdict is taken as byte 5 lands.
    assign w_in_mac     = (r_cnt < BUF_ADDR_W'(C_MAC_ADDR_LEN));
    assign w_own_next   = r_own_ok & (w_byte == w_mac_byte);
    assign w_bc_next    = r_bc_ok  & (w_byte == 8'hFF);
    assign w_mac_reject = MAC_FILTER && (r_cnt == BUF_ADDR_W'(C_MAC_ADDR_LEN - 1))
                          && !(w_own_next || w_bc_next);

    iob_eth_crc32 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (w_sfd_seen),
        .en    (w_byte_done),
        .data  (w_byte),
        .crc   (w_crc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode from the current nibble and rx_dv.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_dv) begin
                    w_state_nxt = (rx_data == C_ETH_PREAMBLE[3:0]) ? S_PREAMBLE : S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!rx_dv)                              w_state_nxt = S_IDLE;
                else if (rx_data == C_ETH_SFD[7:4])      w_state_nxt = S_DATA_LO;
                else if (rx_data != C_ETH_PREAMBLE[3:0]) w_state_nxt = S_DROP;
            end
            S_DATA_LO: w_state_nxt = rx_dv ? S_DATA_HI : S_CHECK;
            S_DATA_HI: begin
                if (!rx_dv)            w_state_nxt = S_CHECK;
                else if (w_mac_reject) w_state_nxt = S_DROP;
                else                   w_state_nxt = S_DATA_LO;
            end
            S_CHECK: w_state_nxt = S_DONE;
            S_DONE: begin
                // Acking during a frame parks in DROP so we never join mid-frame.
                if (rcv_ack) w_state_nxt = rx_dv ? S_DROP : S_IDLE;
            end
            S_DROP: begin
                if (!rx_dv) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte assembly, buffer write port, counters, filter flags and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo        <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_own_ok    <= 1'b0;
            r_bc_ok     <= 1'b0;
            r_buf_we    <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_wdata <= '0;
            r_rx_ready  <= 1'b0;
            r_nbytes    <= '0;
            r_crc_err   <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_buf_we <= 1'b0;
            if ((r_state == S_DATA_LO) && rx_dv) r_lo <= rx_data;
            if (w_sfd_seen) begin
                r_cnt    <= '0;
                r_ovf    <= 1'b0;
                r_own_ok <= 1'b1;
                r_bc_ok  <= 1'b1;
            end
            if (w_byte_done) begin
                if (w_ovf_now) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_buf_we    <= 1'b1;
                    r_buf_addr  <= w_addr_sum[BUF_ADDR_W-1:0];
                    r_buf_wdata <= w_byte;
                end
                if (r_cnt != '1) r_cnt <= r_cnt + BUF_ADDR_W'(1);
                if (w_in_mac) begin
                    r_own_ok <= w_own_next;
                    r_bc_ok  <= w_bc_next;
                end
            end
            if (r_state == S_CHECK) begin
                r_rx_ready <= 1'b1;
                r_nbytes   <= r_cnt;
                r_crc_err  <= (w_crc != C_CRC_RESIDUE);
                r_len_err  <= r_ovf | (r_cnt < BUF_ADDR_W'(C_MIN_FRAME));
            end
            if ((r_state == S_DONE) && rcv_ack) r_rx_ready <= 1'b0;
        end
    end

    assign buf_if.buf_we    = r_buf_we;
    assign buf_if.buf_addr  = r_buf_addr;
    assign buf_if.buf_wdata = r_buf_wdata;
    assign rx_ready         = r_rx_ready;
    assign rx_nbytes        = r_nbytes;
    assign crc_err          = r_crc_err;
    assign len_err          = r_len_err;
    assign busy             = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_iob_eth_rx_mii.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iob_eth_rx_mii
//  Purpose  : Directed self-checking bench for the MII receive framer. Two
//             instances: a full-size buffer (A) and a 64-byte buffer (B).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iob_eth_rx_mii;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [3:0]  rx_data = 4'h0;
    logic        rcv_ack = 1'b0;
    logic        sel = 1'b0;
    logic [47:0] mac = 48'h02_1A_2B_3C_4D_5E;

    logic dv_a, dv_b, ack_a, ack_b;
    assign dv_a  = rx_dv & ~sel;
    assign dv_b  = rx_dv &  sel;
    assign ack_a = rcv_ack & ~sel;
    assign ack_b = rcv_ack &  sel;

    logic        rdy_a, crc_a, len_a, busy_a;
    logic [10:0] nb_a;
    logic        rdy_b, crc_b, len_b, busy_b;
    logic [5:0]  nb_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] fb [0:127];
    int         flen;
    logic [7:0] mem_a [0:2047];
    int         we_a = 0;
    int         we_b = 0;
    int         last_addr_b = 0;

    always #5 clk = ~clk;

    iob_eth_rx_mii_if #(.ADDR_W(11)) bus_a ();
    iob_eth_rx_mii_if #(.ADDR_W(6))  bus_b ();

    iob_eth_rx_mii #(.BUF_ADDR_W(11), .BUF_OFFSET(2), .MAC_FILTER(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_dv(dv_a), .rx_data(rx_data), .mac_addr(mac),
        .rcv_ack(ack_a), .buf_if(bus_a), .rx_ready(rdy_a), .rx_nbytes(nb_a),
        .crc_err(crc_a), .len_err(len_a), .busy(busy_a));

    iob_eth_rx_mii #(.BUF_ADDR_W(6), .BUF_OFFSET(2), .MAC_FILTER(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_dv(dv_b), .rx_data(rx_data), .mac_addr(mac),
        .rcv_ack(ack_b), .buf_if(bus_b), .rx_ready(rdy_b), .rx_nbytes(nb_b),
        .crc_err(crc_b), .len_err(len_b), .busy(busy_b));

    // Buffer model: capture every write strobe half a cycle after it appears.
    always @(negedge clk) begin
        if (bus_a.buf_we) begin
            mem_a[bus_a.buf_addr] = bus_a.buf_wdata;
            we_a++;
        end
        if (bus_b.buf_we) begin
            we_b++;
            last_addr_b = int'(bus_b.buf_addr);
        end
    end

    // Reference Ethernet FCS (reflected table-free form), sent LSB byte first.
    task automatic append_fcs();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < flen; i++) begin
            c = c ^ {24'h0, fb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        fb[flen] = c[7:0]; fb[flen+1] = c[15:8]; fb[flen+2] = c[23:16]; fb[flen+3] = c[31:24];
        flen = flen + 4;
    endtask

    // 64-byte frame: dest, src=own MAC, type 0x0800, 46 payload bytes i, FCS.
    task automatic build_std(input logic [47:0] dest);
        for (int i = 0; i < 6; i++) begin
            fb[i]   = dest[47-8*i -: 8];
            fb[6+i] = mac[47-8*i -: 8];
        end
        fb[12] = 8'h08; fb[13] = 8'h00;
        for (int p = 0; p < 46; p++) fb[14+p] = 8'(p);
        flen = 60;
        append_fcs();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_dv = 1'b1; rx_data = b[3:0];
        @(negedge clk); rx_data = b[7:4];
    endtask

    // Preamble, SFD, frame bytes, then idle long enough for CHECK/DONE.
    // rst_at >= 0 pulses rst_n low for two bytes starting at that byte.
    task automatic send_frame(input int rst_at);
        we_a = 0; we_b = 0;
        for (int i = 0; i < 8; i++) send_byte((i == 7) ? 8'hD5 : 8'h55);
        for (int i = 0; i < flen; i++) begin
            if (i == rst_at) begin
                @(negedge clk); rst_n = 1'b0;
                #1;
                checks++;
                if (bus_a.buf_we !== 1'b0 || rdy_a !== 1'b0 || busy_a !== 1'b0 ||
                    nb_a !== 11'd0 || crc_a !== 1'b0 || len_a !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_async: we=%b rdy=%b busy=%b nb=%0d crc=%b len=%b want all 0",
                             bus_a.buf_we, rdy_a, busy_a, nb_a, crc_a, len_a);
                end
                we_a = 0;
            end
            if (rst_at >= 0 && i == rst_at + 2) rst_n = 1'b1;
            send_byte(fb[i]);
        end
        @(negedge clk); rx_dv = 1'b0; rx_data = 4'h0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk); rcv_ack = 1'b1;
        @(negedge clk); rcv_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.buf_we !== 1'b0 || rdy_a !== 1'b0 || busy_a !== 1'b0 ||
            nb_a !== 11'd0 || crc_a !== 1'b0 || len_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b rdy=%b busy=%b nb=%0d crc=%b len=%b want all 0",
                     bus_a.buf_we, rdy_a, busy_a, nb_a, crc_a, len_a);
        end
        checks++;
        if (dut_a.u_crc.crc !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL reset_crc: got %h want ffffffff", dut_a.u_crc.crc);
        end
    endtask

    task automatic test_nominal();
        build_std(mac);
        send_frame(-1);
        checks++;
        if (we_a != 64) begin errors++; $display("FAIL nom_writes: got %0d want 64", we_a); end
        checks++;
        if (mem_a[2] !== mac[47:40]) begin errors++; $display("FAIL nom_addr2: got %h want %h", mem_a[2], mac[47:40]); end
        checks++;
        if (mem_a[65] !== fb[63]) begin errors++; $display("FAIL nom_addr65: got %h want %h", mem_a[65], fb[63]); end
        checks++;
        if (rdy_a !== 1'b1 || nb_a !== 11'd64) begin
            errors++; $display("FAIL nom_status: rdy=%b nb=%0d want 1 64", rdy_a, nb_a);
        end
        checks++;
        if (crc_a !== 1'b0 || len_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL nom_errs: crc=%b len=%b busy=%b want 0 0 0", crc_a, len_a, busy_a);
        end
        ack();
        checks++;
        if (rdy_a !== 1'b0) begin errors++; $display("FAIL nom_ack: rdy=%b want 0", rdy_a); end
    endtask

    task automatic test_bad_crc();
        build_std(mac);
        fb[34] = 8'h00;  // payload byte 20 corrupted after the FCS was computed
        send_frame(-1);
        checks++;
        if (rdy_a !== 1'b1 || crc_a !== 1'b1 || nb_a !== 11'd64 || len_a !== 1'b0) begin
            errors++; $display("FAIL badcrc_status: rdy=%b crc=%b nb=%0d len=%b want 1 1 64 0",
                               rdy_a, crc_a, nb_a, len_a);
        end
        ack();
    endtask

    task automatic test_mac_filter();
        build_std(mac ^ 48'h1);
        send_frame(-1);
        checks++;
        if (we_a != 6) begin errors++; $display("FAIL filt_writes: got %0d want 6", we_a); end
        checks++;
        if (rdy_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL filt_status: rdy=%b busy=%b want 0 0", rdy_a, busy_a);
        end
        build_std(mac);
        send_frame(-1);
        checks++;
        if (we_a != 64 || rdy_a !== 1'b1 || crc_a !== 1'b0) begin
            errors++; $display("FAIL filt_next: we=%0d rdy=%b crc=%b want 64 1 0", we_a, rdy_a, crc_a);
        end
        ack();
    endtask

    task automatic test_broadcast();
        build_std(48'hFFFF_FFFF_FFFF);
        send_frame(-1);
        checks++;
        if (rdy_a !== 1'b1 || crc_a !== 1'b0 || mem_a[2] !== 8'hFF) begin
            errors++; $display("FAIL bc_accept: rdy=%b crc=%b addr2=%h want 1 0 ff", rdy_a, crc_a, mem_a[2]);
        end
        build_std(mac);
        send_frame(-1);
        checks++;
        if (we_a != 0 || rdy_a !== 1'b1 || nb_a !== 11'd64) begin
            errors++; $display("FAIL bc_held: we=%0d rdy=%b nb=%0d want 0 1 64", we_a, rdy_a, nb_a);
        end
        ack();
        checks++;
        if (rdy_a !== 1'b0) begin errors++; $display("FAIL bc_ack: rdy=%b want 0", rdy_a); end
        send_frame(-1);
        checks++;
        if (we_a != 64 || rdy_a !== 1'b1 || crc_a !== 1'b0) begin
            errors++; $display("FAIL bc_third: we=%0d rdy=%b crc=%b want 64 1 0", we_a, rdy_a, crc_a);
        end
        ack();
    endtask

    task automatic test_short();
        for (int i = 0; i < 6; i++) fb[i] = mac[47-8*i -: 8];
        flen = 6;
        append_fcs();
        send_frame(-1);
        checks++;
        if (rdy_a !== 1'b1 || nb_a !== 11'd10 || len_a !== 1'b1 || crc_a !== 1'b0 || we_a != 10) begin
            errors++; $display("FAIL short: rdy=%b nb=%0d len=%b crc=%b we=%0d want 1 10 1 0 10",
                               rdy_a, nb_a, len_a, crc_a, we_a);
        end
        ack();
    endtask

    // 64-byte buffer, offset 2: bytes 0..61 land at 2..63, the rest are dropped.
    // The 6-bit byte counter saturates at 63, the largest count it can report.
    task automatic test_overflow();
        sel = 1'b1;
        build_std(mac);
        send_frame(-1);
        checks++;
        if (we_b != 62 || last_addr_b != 63) begin
            errors++; $display("FAIL ovf_writes: we=%0d last=%0d want 62 63", we_b, last_addr_b);
        end
        checks++;
        if (rdy_b !== 1'b1 || len_b !== 1'b1 || crc_b !== 1'b0 || nb_b !== 6'd63) begin
            errors++; $display("FAIL ovf_status: rdy=%b len=%b crc=%b nb=%0d want 1 1 0 63",
                               rdy_b, len_b, crc_b, nb_b);
        end
        ack();
        checks++;
        if (rdy_b !== 1'b0) begin errors++; $display("FAIL ovf_ack: rdy=%b want 0", rdy_b); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        build_std(mac);
        send_frame(30);
        checks++;
        if (we_a != 0 || rdy_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL rstmid_ignored: we=%0d rdy=%b busy=%b want 0 0 0", we_a, rdy_a, busy_a);
        end
        send_frame(-1);
        checks++;
        if (we_a != 64 || rdy_a !== 1'b1 || crc_a !== 1'b0 || nb_a !== 11'd64) begin
            errors++; $display("FAIL rstmid_next: we=%0d rdy=%b crc=%b nb=%0d want 64 1 0 64",
                               we_a, rdy_a, crc_a, nb_a);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_crc();
        test_mac_filter();
        test_broadcast();
        test_short();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
